// File: rtl/cpu_pkg.sv
// Shared CPU constants and writeback entry type.
// ID/EX decode uses the same WB_SEL and FUNCT3 codes.
package cpu_pkg;

  localparam int unsigned CPU_XLEN = 32;
  localparam int unsigned REG_AW   = 5;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;
  localparam logic [1:0] WB_SEL_RSVD = 2'b11;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  typedef struct packed {
    logic                reg_write;
    logic [REG_AW-1:0]   rd;
    logic [CPU_XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Load data formatter: selects the addressed byte/half of an aligned word
// and sign- or zero-extends it according to funct3.
module load_align
  import cpu_pkg::*;
(
  input  logic [2:0]          i_funct3,
  input  logic [1:0]          i_addr_lo,
  input  logic [CPU_XLEN-1:0] i_raw,
  output logic [CPU_XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_raw[{i_addr_lo, 3'b000} +: 8];
    w_half = i_addr_lo[1] ? i_raw[31:16] : i_raw[15:0];
    case (i_funct3)
      FUNCT3_LB:  o_data = {{(CPU_XLEN-8){w_byte[7]}}, w_byte};
      FUNCT3_LH:  o_data = {{(CPU_XLEN-16){w_half[15]}}, w_half};
      FUNCT3_LBU: o_data = {{(CPU_XLEN-8){1'b0}}, w_byte};
      FUNCT3_LHU: o_data = {{(CPU_XLEN-16){1'b0}}, w_half};
      default:    o_data = i_raw;  // LW and undefined encodings pass the word through
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: buffers retiring instructions in a small FIFO, drives the
// register-file write port from its head, offers bypass lookup and counts retirements.
module wb_stage
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN  = CPU_XLEN,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_reg_write,
  input  logic [4:0]      in_rd_addr,
  input  logic [1:0]      in_wb_sel,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_load_data,
  input  logic [2:0]      in_funct3,
  input  logic [1:0]      in_addr_lo,
  input  logic [XLEN-1:0] in_pc_plus4,
  input  logic            wb_stall,
  output logic            rd_we,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_wdata,
  input  logic [4:0]      rs1_query,
  input  logic [4:0]      rs2_query,
  output logic            rs1_hit,
  output logic [XLEN-1:0] rs1_hit_data,
  output logic            rs2_hit,
  output logic [XLEN-1:0] rs2_hit_data,
  output logic [63:0]     instret
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [63:0]      r_instret;

  logic             w_push;
  logic             w_pop;
  logic             w_head_valid;
  wb_entry_t        w_head;
  wb_entry_t        w_new;
  logic [XLEN-1:0]  w_load_data;
  logic [PTR_W-1:0] w_idx;

  load_align u_load_align (
    .i_funct3  (in_funct3),
    .i_addr_lo (in_addr_lo),
    .i_raw     (in_load_data),
    .o_data    (w_load_data)
  );

  assign in_ready     = r_count < CNT_W'(DEPTH);
  assign w_push       = in_valid & in_ready;
  assign w_head_valid = r_count != '0;
  assign w_pop        = w_head_valid & ~wb_stall;
  assign w_head       = r_mem[r_rd_ptr];

  // Incoming entry; writes to x0 are demoted to non-writing retirements
  always_comb begin
    w_new.reg_write = in_reg_write & (in_rd_addr != '0);
    w_new.rd        = in_rd_addr;
    case (in_wb_sel)
      WB_SEL_LOAD: w_new.data = w_load_data;
      WB_SEL_PC4:  w_new.data = in_pc_plus4;
      default:     w_new.data = in_alu_result;
    endcase
  end

  assign rd_we    = w_head_valid & w_head.reg_write & ~wb_stall;
  assign rd_addr  = w_head_valid ? w_head.rd : '0;
  assign rd_wdata = w_head_valid ? w_head.data : '0;
  assign instret  = r_instret;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_instret <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
        r_instret <= r_instret + 64'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage is qualified by r_count, so it needs no reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_new;
  end

  // Bypass: walk oldest to youngest so the last match wins
  always_comb begin
    rs1_hit      = 1'b0;
    rs1_hit_data = '0;
    rs2_hit      = 1'b0;
    rs2_hit_data = '0;
    w_idx        = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_idx = r_rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < r_count) && r_mem[w_idx].reg_write) begin
        if ((rs1_query != '0) && (r_mem[w_idx].rd == rs1_query)) begin
          rs1_hit      = 1'b1;
          rs1_hit_data = r_mem[w_idx].data;
        end
        if ((rs2_query != '0) && (r_mem[w_idx].rd == rs2_query)) begin
          rs2_hit      = 1'b1;
          rs2_hit_data = r_mem[w_idx].data;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: queue-based reference model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_wb_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_reg_write = 1'b0;
  logic [4:0]  in_rd_addr = '0;
  logic [1:0]  in_wb_sel = '0;
  logic [31:0] in_alu_result = '0;
  logic [31:0] in_load_data = '0;
  logic [2:0]  in_funct3 = '0;
  logic [1:0]  in_addr_lo = '0;
  logic [31:0] in_pc_plus4 = '0;
  logic        wb_stall = 1'b0;
  logic        rd_we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic [4:0]  rs1_query = '0;
  logic [4:0]  rs2_query = '0;
  logic        rs1_hit;
  logic [31:0] rs1_hit_data;
  logic        rs2_hit;
  logic [31:0] rs2_hit_data;
  logic [63:0] instret;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_reg_write(in_reg_write), .in_rd_addr(in_rd_addr), .in_wb_sel(in_wb_sel),
    .in_alu_result(in_alu_result), .in_load_data(in_load_data), .in_funct3(in_funct3),
    .in_addr_lo(in_addr_lo), .in_pc_plus4(in_pc_plus4), .wb_stall(wb_stall),
    .rd_we(rd_we), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
    .rs1_query(rs1_query), .rs2_query(rs2_query),
    .rs1_hit(rs1_hit), .rs1_hit_data(rs1_hit_data),
    .rs2_hit(rs2_hit), .rs2_hit_data(rs2_hit_data), .instret(instret)
  );

  typedef struct {
    bit        we;
    bit [4:0]  rd;
    bit [31:0] data;
  } ent_t;

  ent_t            q[$];
  longint unsigned m_instret = 0;
  int              n_vec = 0;
  int              n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit [31:0] fmt(input bit [1:0] sel, input bit [2:0] f3, input bit [1:0] lo,
                                    input bit [31:0] alu, input bit [31:0] raw, input bit [31:0] pc4);
    bit [31:0] b, h;
    b = (raw >> (8 * lo)) & 32'hFF;
    h = (raw >> (lo >= 2 ? 16 : 0)) & 32'hFFFF;
    if (sel == 2'd2) return pc4;
    if (sel != 2'd1) return alu;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return raw;
    endcase
  endfunction

  task automatic check_all();
    bit e_hit1, e_hit2;
    bit [31:0] e_d1, e_d2;
    e_hit1 = 0; e_hit2 = 0; e_d1 = 0; e_d2 = 0;
    foreach (q[i]) begin
      if (q[i].we && rs1_query != 0 && q[i].rd == rs1_query) begin e_hit1 = 1; e_d1 = q[i].data; end
      if (q[i].we && rs2_query != 0 && q[i].rd == rs2_query) begin e_hit2 = 1; e_d2 = q[i].data; end
    end
    chk("in_ready", in_ready, 64'(q.size() < DEPTH));
    chk("rd_we", rd_we, 64'(q.size() > 0 && q[0].we && !wb_stall));
    chk("rd_addr", rd_addr, (q.size() > 0) ? 64'(q[0].rd) : 64'd0);
    chk("rd_wdata", rd_wdata, (q.size() > 0) ? 64'(q[0].data) : 64'd0);
    chk("rs1_hit", rs1_hit, 64'(e_hit1));
    chk("rs1_hit_data", rs1_hit_data, 64'(e_d1));
    chk("rs2_hit", rs2_hit, 64'(e_hit2));
    chk("rs2_hit_data", rs2_hit_data, 64'(e_d2));
    chk("instret", instret, m_instret);
  endtask

  // One clock: model decides accept/pop from pre-edge state, then checks post-edge outputs
  task automatic step();
    bit acc, pop;
    ent_t e;
    acc = in_valid && (q.size() < DEPTH);
    pop = (q.size() > 0) && !wb_stall;
    e.we   = in_reg_write && (in_rd_addr != 0);
    e.rd   = in_rd_addr;
    e.data = fmt(in_wb_sel, in_funct3, in_addr_lo, in_alu_result, in_load_data, in_pc_plus4);
    @(posedge clk);
    #1;
    if (pop) begin
      void'(q.pop_front());
      m_instret++;
    end
    if (acc) q.push_back(e);
    check_all();
  endtask

  task automatic push(input bit rw, input bit [4:0] rd, input bit [1:0] sel, input bit [31:0] alu,
                      input bit [31:0] raw, input bit [2:0] f3, input bit [1:0] lo, input bit [31:0] pc4);
    in_valid = 1; in_reg_write = rw; in_rd_addr = rd; in_wb_sel = sel; in_alu_result = alu;
    in_load_data = raw; in_funct3 = f3; in_addr_lo = lo; in_pc_plus4 = pc4;
  endtask

  typedef struct { bit [2:0] f3; bit [1:0] lo; bit [31:0] exp; } ld_vec_t;
  ld_vec_t ld_tab[5];

  initial begin
    ld_tab[0] = '{3'b000, 2'd0, 32'hFFFF_FF80};
    ld_tab[1] = '{3'b100, 2'd0, 32'h0000_0080};
    ld_tab[2] = '{3'b001, 2'd2, 32'hFFFF_8081};
    ld_tab[3] = '{3'b101, 2'd2, 32'h0000_8081};
    ld_tab[4] = '{3'b010, 2'd0, 32'h8081_7F80};

    // Reset state
    #1;
    chk("rst_rd_we", rd_we, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_rd_wdata", rd_wdata, 0);
    chk("rst_rs1_hit", rs1_hit, 0);
    chk("rst_instret", instret, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    check_all();

    // 1: ALU write, one-cycle latency
    push(1, 5'd5, 2'b00, 32'h0000_1234, 0, 0, 0, 0);
    step();
    chk("t1_rd_we", rd_we, 1);
    chk("t1_rd_addr", rd_addr, 5);
    chk("t1_rd_wdata", rd_wdata, 32'h1234);
    in_valid = 0;
    step();
    chk("t1_instret", instret, 1);

    // 2: load formatting
    for (int i = 0; i < 5; i++) begin
      push(1, 5'd9, 2'b01, 32'hDEAD_BEEF, 32'h8081_7F80, ld_tab[i].f3, ld_tab[i].lo, 32'h0);
      step();
      chk($sformatf("t2_load%0d", i), rd_wdata, ld_tab[i].exp);
      in_valid = 0;
      step();
    end

    // 3: rd=0 retires without writing
    push(1, 5'd0, 2'b00, 32'h0000_DEAD, 0, 0, 0, 0);
    step();
    chk("t3_rd_we", rd_we, 0);
    in_valid = 0;
    step();
    chk("t3_instret", instret, 7);

    // 4: stall fills FIFO, third push ignored, in-order drain
    wb_stall = 1;
    push(1, 5'd10, 2'b00, 32'hA, 0, 0, 0, 0); step();
    push(1, 5'd11, 2'b00, 32'hB, 0, 0, 0, 0); step();
    chk("t4_full", in_ready, 0);
    push(1, 5'd12, 2'b00, 32'hC, 0, 0, 0, 0); step();
    chk("t4_frozen_instret", instret, 7);
    in_valid = 0; wb_stall = 0;
    #1;
    chk("t4_w1_we", rd_we, 1);
    chk("t4_w1_addr", rd_addr, 10);
    step();
    chk("t4_w2_addr", rd_addr, 11);
    chk("t4_w2_data", rd_wdata, 32'hB);
    step();
    chk("t4_ready", in_ready, 1);
    chk("t4_empty_we", rd_we, 0);

    // 5: bypass picks youngest match; query 0 never hits
    wb_stall = 1;
    push(1, 5'd7, 2'b00, 32'h11, 0, 0, 0, 0); step();
    push(1, 5'd7, 2'b00, 32'h22, 0, 0, 0, 0); step();
    in_valid = 0; rs1_query = 5'd7; rs2_query = 5'd0;
    #1;
    chk("t5_rs1_hit", rs1_hit, 1);
    chk("t5_rs1_data", rs1_hit_data, 32'h22);
    chk("t5_rs2_hit", rs2_hit, 0);
    chk("t5_rs2_data", rs2_hit_data, 0);
    wb_stall = 0;
    step(); step();

    // Back-to-back traffic with push+pop on the same edge (pointer wrap)
    for (int i = 0; i < 6; i++) begin
      push(i % 3 != 2, 5'(i + 1), 2'(i), 32'h100 + 32'(i), 32'hF00D_0000 + 32'(i), 3'(i), 2'(i), 32'h2000 + 32'(i));
      rs1_query = 5'(i); rs2_query = 5'(i + 1);
      step();
    end
    in_valid = 0; step(); step();

    // Random stall/valid mix
    for (int i = 0; i < 60; i++) begin
      push($urandom_range(0, 1), 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom,
           $urandom, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom);
      in_valid = $urandom_range(0, 1);
      wb_stall = ($urandom_range(0, 3) == 0);
      rs1_query = 5'($urandom_range(0, 7)); rs2_query = 5'($urandom_range(0, 7));
      step();
    end
    in_valid = 0; wb_stall = 0; step(); step(); step();

    // 6: reset mid-cycle with two buffered writes
    wb_stall = 1;
    push(1, 5'd20, 2'b00, 32'h55, 0, 0, 0, 0); step();
    push(1, 5'd21, 2'b00, 32'h66, 0, 0, 0, 0); step();
    in_valid = 0; wb_stall = 0;
    #1;
    chk("t6_pre_we", rd_we, 1);
    #2;
    rst = 1;
    #1;
    q.delete();
    m_instret = 0;
    chk("t6_rst_we", rd_we, 0);
    chk("t6_rst_instret", instret, 0);
    chk("t6_rst_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("t6_hold_we", rd_we, 0);
    rst = 0;
    step();
    chk("t6_after_we", rd_we, 0);
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
